seq_1101_tx: RTL and testbench
==============================

# seq_1101_tx

Serial frame transmitter that drives the single-bit line watched by the team's 1101 sequence detector. It accepts a parallel payload word over a valid/ready handshake and emits the sync pattern 1101 followed by the payload, MSB first. It then emits a run of idle zeros so the detector returns to its start state before the next frame. It sits upstream of the detector, as the stimulus source in system builds and as the loopback partner in the detector's bench.

## Interface
- PAYLOAD_W, 8, payload bits per frame (>= 1)
- CLKS_PER_BIT, 1, CLK cycles each line bit is held (>= 1)
- GAP_BITS, 2, idle zero bits appended after each frame (>= 1)

- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-low
- DIN  in  PAYLOAD_W  payload word, sampled on accept
- DIN_VALID  in  1  payload offered
- DIN_READY  out  1  block can accept; combinational, high only in IDLE
- TX  out  1  serial line, registered; idle level 0
- TX_EN  out  1  registered; high while sync or payload bits are on TX
- BUSY  out  1  registered; high from the first sync bit through the last gap bit
- DONE  out  1  registered one-cycle pulse on frame completion

## Operation
- States: IDLE, SYNC, DATA, GAP.
- IDLE: TX=0, TX_EN=0, BUSY=0, DIN_READY=1. An accept occurs on a rising edge with DIN_VALID=1 and DIN_READY=1. On accept, DIN is latched into the shift register and the FSM moves to SYNC with bit index 0.
- SYNC: TX drives 1,1,0,1 in order, one bit per bit period, with TX_EN=1. After the 4th bit the FSM moves to DATA.
- DATA: TX drives the latched payload MSB first, PAYLOAD_W bits, with TX_EN=1. After the last bit the FSM moves to GAP.
- GAP: TX=0 and TX_EN=0 for GAP_BITS bit periods, with BUSY=1. At the end of the last gap period the FSM moves to IDLE and DONE=1 for exactly that one cycle.
- Bit period: a tick counter counts 0..CLKS_PER_BIT-1. The bit index advances only on the terminal count. The counter clears on accept and on every state change.
- DIN_VALID and DIN changes outside IDLE are ignored. The latched word is unaffected.
- A frame never aborts except on reset.
- Width rules:
  - Tick counter is $clog2(CLKS_PER_BIT) bits, minimum 1.
  - Bit index is $clog2(max(4, PAYLOAD_W, GAP_BITS)) bits, minimum 1.
  - No wrap-around is legal. The index resets at each state entry.
- Reset, at any time including mid-frame:
  - Asynchronous to IDLE. TX=0, TX_EN=0, BUSY=0, DONE=0; DIN_READY reads 1.
  - The shift register and counters clear, and the partial frame is discarded with no DONE.

## Timing
- Cycle n is counted from the accept edge (n=0).
- The first sync bit appears on TX in cycle 1. There is no extra pipeline latency.
- Bit k (0-based over sync+payload+gap) occupies cycles 1+k*CLKS_PER_BIT .. (k+1)*CLKS_PER_BIT.
- The frame length is L = 4+PAYLOAD_W+GAP_BITS bits. DONE=1 and DIN_READY=1 in cycle L*CLKS_PER_BIT+1.
- A new accept is allowed in the DONE cycle. The back-to-back frame period is therefore L*CLKS_PER_BIT+1 cycles, with TX=0 in the DONE cycle.
- If DIN_VALID is already high in the DONE cycle, that edge accepts the next frame.

## Structure
- Shared package seq_1101_pkg holds:
  - state encoding localparams (IDLE, SYNC, DATA, GAP)
  - SYNC_PATTERN=4'b1101 and SYNC_LEN=4
  - the max() helper used for width calculation
- One sub-module, bit_tick_gen: parameterised CLKS_PER_BIT counter with a clear input, producing a bit_end strobe. The FSM, shift register and output registers stay in seq_1101_tx.

## Test plan
- Basic frame: PAYLOAD_W=8, CLKS_PER_BIT=1, GAP_BITS=2, DIN=8'hA5 accepted at cycle 0 -> TX in cycles 1..14 is 1101 10100101 00; TX_EN=1 in cycles 1..12 only; DONE=1 in cycle 15 only.
- Stretched bits: CLKS_PER_BIT=3, DIN=8'h0F -> each bit held 3 cycles; DONE in cycle 43; BUSY high in cycles 1..42.
- Back-to-back: DIN_VALID held high with 8'h3C then 8'hC3 -> second accept in cycle 15, second frame's first sync bit in cycle 16, no idle cycle lost, both DONE pulses present.
- Busy ignore: DIN_VALID pulsed with 8'hFF in cycle 6 of an 8'h00 frame -> DIN_READY=0, payload bits remain all zero, exactly one DONE.
- Reset mid-payload: RST low in cycle 7 -> TX, TX_EN and BUSY are 0 immediately (asynchronous); no DONE; after release DIN_READY=1 and a new 8'h81 frame transmits correctly.
- Loopback into the 1101 detector with DIN=8'h00 -> detector output pulses exactly once, during cycle 4 (4th sync bit), and never during payload or gap.

Source files
------------

// File: rtl/seq_1101_pkg.sv
// Shared definitions for the 1101 sync-pattern frame transmitter.
package seq_1101_pkg;

    // State encoding values.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StSync = SYNC,
        StData = DATA,
        StGap  = GAP
    } state_e;

    // Sync pattern, sent MSB first.
    localparam logic [3:0]  SYNC_PATTERN = 4'b1101;
    localparam int unsigned SYNC_LEN     = 4;

    // Helper for sizing counters.
    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period tick counter: counts 0..CLKS_PER_BIT-1 and strobes bit_end_o on the terminal count.
module bit_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CntW-1:0] tick_q, tick_d;

    assign bit_end_o = (tick_q == CntW'(CLKS_PER_BIT - 1));

    // Wrap on terminal count, restart on clear.
    always_comb begin
        tick_d = tick_q + 1'b1;
        if (clr_i || bit_end_o) begin
            tick_d = '0;
        end
    end

    // Tick counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/seq_1101_tx.sv
// Serial frame transmitter: sends 1101, then the payload MSB first, then idle gap zeros.
module seq_1101_tx
    import seq_1101_pkg::*;
#(
    parameter int unsigned PAYLOAD_W    = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PAYLOAD_W-1:0] DIN,
    input  logic                 DIN_VALID,
    output logic                 DIN_READY,
    output logic                 TX,
    output logic                 TX_EN,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned IdxMax = max(max(SYNC_LEN, PAYLOAD_W), GAP_BITS);
    localparam int unsigned IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [PAYLOAD_W-1:0]   shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   tx_en_q, tx_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;
    logic                   tick_clr;
    logic [1:0]             sync_pos;

    assign DIN_READY = (state_q == StIdle);
    assign TX        = tx_q;
    assign TX_EN     = tx_en_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

    // Hold the tick counter at zero while idle and restart it on every state change.
    assign tick_clr = (state_q == StIdle) || (state_d != state_q);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_tick_gen (
        .CLK      (CLK),
        .RST      (RST),
        .clr_i    (tick_clr),
        .bit_end_o(bit_end)
    );

    // Next-state, bit index, shift register and next line values.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
        tx_d     = 1'b0;
        tx_en_d  = 1'b0;
        busy_d   = 1'b0;
        sync_pos = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (DIN_VALID) begin
                    state_d = StSync;
                    idx_d   = '0;
                    shreg_d = DIN;
                end
            end
            StSync: begin
                if (bit_end) begin
                    if (idx_q == IdxW'(SYNC_LEN - 1)) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == IdxW'(PAYLOAD_W - 1)) begin
                        state_d = StGap;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            StGap: begin
                if (bit_end) begin
                    if (idx_q == IdxW'(GAP_BITS - 1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the upcoming state.
        sync_pos = 2'(SYNC_LEN - 1) - idx_d[1:0];
        unique case (state_d)
            StSync: begin
                tx_d    = SYNC_PATTERN[sync_pos];
                tx_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            StData: begin
                tx_d    = shreg_d[PAYLOAD_W-1];
                tx_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            StGap: begin
                busy_d = 1'b1;
            end
            default: begin
                tx_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_1101_tx.sv
// Bench for seq_1101_tx: one instance at 1 clock/bit, one at 3 clocks/bit.
module tb_seq_1101_tx;

    localparam int unsigned PW  = 8;
    localparam int unsigned GB  = 2;
    localparam int unsigned LEN = 4 + PW + GB;

    logic       CLK;
    logic       RST;
    logic [7:0] din   [2];
    logic       valid [2];
    logic       ready [2];
    logic       tx_w  [2];
    logic       en_w  [2];
    logic       busy_w[2];
    logic       done_w[2];

    int checks;
    int errors;

    seq_1101_tx #(
        .PAYLOAD_W   (PW),
        .CLKS_PER_BIT(1),
        .GAP_BITS    (GB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (din[0]),
        .DIN_VALID(valid[0]),
        .DIN_READY(ready[0]),
        .TX       (tx_w[0]),
        .TX_EN    (en_w[0]),
        .BUSY     (busy_w[0]),
        .DONE     (done_w[0])
    );

    seq_1101_tx #(
        .PAYLOAD_W   (PW),
        .CLKS_PER_BIT(3),
        .GAP_BITS    (GB)
    ) dut3 (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (din[1]),
        .DIN_VALID(valid[1]),
        .DIN_READY(ready[1]),
        .TX       (tx_w[1]),
        .TX_EN    (en_w[1]),
        .BUSY     (busy_w[1]),
        .DONE     (done_w[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line bit k of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        logic [3:0] sp;
        sp = 4'b1101;
        if (k < 4) return sp[3-k];
        if (k < 4 + PW) return w[11-k];
        return 1'b0;
    endfunction

    task automatic idle_check(input int i, input int k);
        repeat (k) begin
            @(negedge CLK);
            check($sformatf("idle_ready%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("idle_tx%0d", i), 32'(tx_w[i]), 32'd0);
            check($sformatf("idle_busy%0d", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("idle_done%0d", i), 32'(done_w[i]), 32'd0);
        end
    endtask

    // Called at a negedge while idle; the following posedge is the accept edge.
    task automatic start_frame(input int i, input logic [7:0] w);
        din[i]   = w;
        valid[i] = 1'b1;
        check($sformatf("accept_ready%0d", i), 32'(ready[i]), 32'd1);
        @(posedge CLK);
    endtask

    // Checks cycles 1..LEN*cpb+1 after an accept; returns at the negedge of the DONE cycle.
    task automatic frame_check(input int i, input int cpb, input logic [7:0] w,
                               input bit keep_valid, input logic [7:0] next_w,
                               input int inject_n, input int abort_n, input bit loopback);
        int         total;
        int         k;
        int         det_cnt;
        logic [3:0] hist;
        logic       etx, een, ebusy, edone, erdy;
        total   = LEN * cpb;
        det_cnt = 0;
        hist    = 4'b0000;
        for (int n = 1; n <= total + 1; n++) begin
            @(negedge CLK);
            if (n <= total) begin
                k     = (n - 1) / cpb;
                etx   = exp_bit(w, k);
                een   = (k < 4 + PW);
                ebusy = 1'b1;
                edone = 1'b0;
                erdy  = 1'b0;
            end else begin
                etx   = 1'b0;
                een   = 1'b0;
                ebusy = 1'b0;
                edone = 1'b1;
                erdy  = 1'b1;
            end
            check($sformatf("tx%0d_w%02h_n%0d", i, w, n), 32'(tx_w[i]), 32'(etx));
            check($sformatf("txen%0d_n%0d", i, n), 32'(en_w[i]), 32'(een));
            check($sformatf("busy%0d_n%0d", i, n), 32'(busy_w[i]), 32'(ebusy));
            check($sformatf("done%0d_n%0d", i, n), 32'(done_w[i]), 32'(edone));
            check($sformatf("ready%0d_n%0d", i, n), 32'(ready[i]), 32'(erdy));
            if (loopback && n <= total) begin
                hist = {hist[2:0], tx_w[i]};
                if (hist == 4'b1101) det_cnt++;
                check($sformatf("detect_n%0d", n), 32'(hist == 4'b1101), 32'(n == 4));
            end
            if (n == abort_n) begin
                RST = 1'b0;
                #1;
                check("rst_tx", 32'(tx_w[i]), 32'd0);
                check("rst_txen", 32'(en_w[i]), 32'd0);
                check("rst_busy", 32'(busy_w[i]), 32'd0);
                check("rst_done", 32'(done_w[i]), 32'd0);
                check("rst_ready", 32'(ready[i]), 32'd1);
                return;
            end
            if (n == 1) begin
                if (keep_valid) din[i] = next_w;
                else valid[i] = 1'b0;
            end
            if (n == inject_n) begin
                valid[i] = 1'b1;
                din[i]   = 8'hFF;
            end else if (n == inject_n + 1) begin
                valid[i] = 1'b0;
            end
        end
        if (loopback) check("detect_count", 32'(det_cnt), 32'd1);
    endtask

    initial begin
        logic [7:0] w;
        checks   = 0;
        errors   = 0;
        RST      = 1'b0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        din[0]   = 8'h00;
        din[1]   = 8'h00;

        // Reset state.
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ready%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("reset_tx%0d", i), 32'(tx_w[i]), 32'd0);
            check($sformatf("reset_txen%0d", i), 32'(en_w[i]), 32'd0);
            check($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("reset_done%0d", i), 32'(done_w[i]), 32'd0);
        end
        RST = 1'b1;
        idle_check(0, 2);

        // Basic frame.
        start_frame(0, 8'hA5);
        frame_check(0, 1, 8'hA5, 1'b0, 8'h00, -1, -1, 1'b0);
        idle_check(0, 2);

        // Stretched bits.
        start_frame(1, 8'h0F);
        frame_check(1, 3, 8'h0F, 1'b0, 8'h00, -1, -1, 1'b0);
        idle_check(1, 2);

        // Back-to-back with DIN_VALID held high; DIN changes mid-frame are ignored.
        start_frame(0, 8'h3C);
        frame_check(0, 1, 8'h3C, 1'b1, 8'hC3, -1, -1, 1'b0);
        @(posedge CLK);
        frame_check(0, 1, 8'hC3, 1'b0, 8'h00, -1, -1, 1'b0);
        idle_check(0, 2);

        // Valid pulse while busy is ignored; only one DONE.
        start_frame(0, 8'h00);
        frame_check(0, 1, 8'h00, 1'b0, 8'h00, 6, -1, 1'b0);
        idle_check(0, 4);

        // Loopback detector sees 1101 exactly once.
        start_frame(0, 8'h00);
        frame_check(0, 1, 8'h00, 1'b0, 8'h00, -1, -1, 1'b1);
        idle_check(0, 1);

        // Reset mid-payload, then a clean frame.
        start_frame(0, 8'h5A);
        frame_check(0, 1, 8'h5A, 1'b0, 8'h00, -1, 7, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            check("inrst_done", 32'(done_w[0]), 32'd0);
            check("inrst_busy", 32'(busy_w[0]), 32'd0);
        end
        RST = 1'b1;
        check("post_rst_ready", 32'(ready[0]), 32'd1);
        idle_check(0, 2);
        start_frame(0, 8'h81);
        frame_check(0, 1, 8'h81, 1'b0, 8'h00, -1, -1, 1'b0);

        // Random payloads with random idle spacing (including an immediate re-accept).
        for (int r = 0; r < 6; r++) begin
            w = 8'($urandom);
            start_frame(0, w);
            frame_check(0, 1, w, 1'b0, 8'h00, -1, -1, 1'b0);
            idle_check(0, int'($urandom_range(0, 2)));
        end
        for (int r = 0; r < 2; r++) begin
            w = 8'($urandom);
            idle_check(1, 1);
            start_frame(1, w);
            frame_check(1, 3, w, 1'b0, 8'h00, -1, -1, 1'b0);
        end
        idle_check(1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
